// File: rtl/vdu_fetch_if.sv
// rtl/vdu_fetch_if.sv - video/memory port bundle for the vdu_fetch prefetch buffer
//
// Purpose: groups the VDU-facing word port and the memory-controller read port.
//   master : the prefetch buffer side (vdu_fetch)
//   slave  : the surrounding system (VDU address source plus memory controller)
// Signals:
//   video_addr  [21:0] word address requested by the VDU (byte address bits 24:3)
//   video_data  [63:0] word at video_addr when video_valid, else 0
//   video_valid        head word is valid and matches video_addr
//   mem_req            read request to the memory controller
//   mem_addr    [21:0] word address of the request
//   mem_ack            request accepted this cycle (only while mem_req is high)
//   mem_rvalid         one read word returned, in request order
//   mem_rdata   [63:0] returned word
interface vdu_fetch_if;
    logic [21:0] video_addr;
    logic [63:0] video_data;
    logic        video_valid;
    logic        mem_req;
    logic [21:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    modport master (
        input  video_addr,
        output video_data,
        output video_valid,
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        output video_addr,
        input  video_data,
        input  video_valid,
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/vdu_fetch.sv
// rtl/vdu_fetch.sv - video prefetch buffer feeding the VDU from an in-order word FIFO
//
// Purpose: presents the 64-bit word addressed by video_addr and keeps the following
// words prefetched from memory. A sequential advance of video_addr pops the FIFO;
// any other change flushes it and restarts fetching at the new address. Requests
// that were already accepted when a flush happens are counted in 'discard' so
// their returns can be dropped without disturbing the new stream.
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-high reset
//   vif             vdu_fetch_if.master (video word port + memory read port)
//   underrun_count  [15:0] saturating count of underrun flushes
//                   (present only when VDU_FETCH_UNDERRUN_EN is defined)
//
// Parameter:
//   DEPTH           FIFO depth in 64-bit words; power of two, at least 4
//
// Configuration macro: VDU_FETCH_UNDERRUN_EN
module vdu_fetch #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    vdu_fetch_if.master vif
`ifdef VDU_FETCH_UNDERRUN_EN
    ,
    output logic [15:0] underrun_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 2;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;
    typedef logic [21:0]   addr_t;
    typedef logic [OW-1:0] occ_t;

    // Registered state
    addr_t       head_addr_q,  head_addr_d;
    addr_t       fetch_addr_q, fetch_addr_d;
    cnt_t        count_q,      count_d;
    cnt_t        inflight_q,   inflight_d;
    cnt_t        discard_q,    discard_d;
    ptr_t        rd_ptr_q,     rd_ptr_d;
    ptr_t        wr_ptr_q,     wr_ptr_d;
    logic [63:0] fifo_q [DEPTH];

    // Per-cycle decode
    addr_t next_addr;
    logic  hit;
    logic  seq;
    logic  pop;
    logic  flush;
    logic  accept;
    logic  store;
    logic  drop;
    occ_t  occupancy;

    // head_addr + 1 wraps modulo 2^22, so 3FFFFF -> 0 is a sequential step.
    assign next_addr = head_addr_q + 22'd1;
    assign hit       = (vif.video_addr == head_addr_q);
    assign seq       = (vif.video_addr == next_addr);
    assign pop       = seq && (count_q != '0);
    // Sequential step with nothing held is an underrun and restarts like a jump.
    assign flush     = !hit && !pop;

    // Every accepted-but-unreturned request owns a slot, wanted or not, so the
    // FIFO can never be overrun by returns.
    assign occupancy = occ_t'(count_q) + occ_t'(inflight_q) + occ_t'(discard_q);
    assign vif.mem_req  = (occupancy < occ_t'(DEPTH));
    assign vif.mem_addr = fetch_addr_q;

    assign accept = vif.mem_req && vif.mem_ack;
    // Returns landing in a flush cycle are stale by definition and are folded
    // into the discard update instead.
    assign store  = vif.mem_rvalid && !flush && (discard_q == '0);
    assign drop   = vif.mem_rvalid && !flush && (discard_q != '0);

    assign vif.video_valid = hit && (count_q != '0);
    assign vif.video_data  = vif.video_valid ? fifo_q[rd_ptr_q] : 64'd0;

    always_comb begin
        head_addr_d  = head_addr_q;
        fetch_addr_d = fetch_addr_q;
        count_d      = count_q;
        inflight_d   = inflight_q;
        discard_d    = discard_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;

        if (flush) begin
            head_addr_d  = vif.video_addr;
            fetch_addr_d = vif.video_addr;
            count_d      = '0;
            inflight_d   = '0;
            // Everything outstanding becomes stale, including an ack taken this
            // cycle; a word returning this cycle settles one of them.
            discard_d    = discard_q + inflight_q + cnt_t'(accept) - cnt_t'(vif.mem_rvalid);
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
        end else begin
            if (pop) begin
                head_addr_d = next_addr;
                rd_ptr_d    = rd_ptr_q + ptr_t'(1);
            end
            if (accept) begin
                fetch_addr_d = fetch_addr_q + 22'd1;
            end
            if (store) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            // A pop and a store in the same cycle cancel in count.
            count_d    = count_q + cnt_t'(store) - cnt_t'(pop);
            inflight_d = inflight_q + cnt_t'(accept) - cnt_t'(store);
            discard_d  = discard_q - cnt_t'(drop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_addr_q  <= '0;
            fetch_addr_q <= '0;
            count_q      <= '0;
            inflight_q   <= '0;
            discard_q    <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            head_addr_q  <= head_addr_d;
            fetch_addr_q <= fetch_addr_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            discard_q    <= discard_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    // Word storage carries no reset: validity is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (store) begin
            fifo_q[wr_ptr_q] <= vif.mem_rdata;
        end
    end

`ifdef VDU_FETCH_UNDERRUN_EN
    logic [15:0] underrun_q;

    // flush together with seq can only mean a sequential step with count == 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_q <= '0;
        end else if (flush && seq && (underrun_q != 16'hFFFF)) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end

    assign underrun_count = underrun_q;
`endif

endmodule

// File: tb/tb_vdu_fetch.sv
// tb/tb_vdu_fetch.sv - self-checking bench for vdu_fetch with a latency-programmable memory model
module tb_vdu_fetch;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vdu_fetch_if bus ();

`ifdef VDU_FETCH_UNDERRUN_EN
    logic [15:0] underrun_count;
`endif

    vdu_fetch #(.DEPTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .vif            (bus)
`ifdef VDU_FETCH_UNDERRUN_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mdata(input logic [21:0] a);
        return {a ^ 22'h155555, 20'hC0FFE, a};
    endfunction

    // Memory model: acks while enabled, returns in order after 'lat' cycles.
    logic        ack_en;
    int          lat;
    logic        req_chk;
    logic [21:0] req_exp;
    logic [21:0] pend_a[$];
    int          pend_t[$];

    always @(negedge clk) begin
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 64'd0;
        if (reset) begin
            pend_a.delete();
            pend_t.delete();
        end else begin
            if (ack_en && bus.mem_req) begin
                bus.mem_ack = 1'b1;
                if (req_chk) begin
                    check("mem_addr_seq", 64'(bus.mem_addr), 64'(req_exp));
                    req_exp = req_exp + 22'd1;
                end
                pend_a.push_back(bus.mem_addr);
                pend_t.push_back(cyc + lat);
            end
            if (pend_a.size() != 0 && pend_t[0] <= cyc) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = mdata(pend_a.pop_front());
                void'(pend_t.pop_front());
            end
        end
    end

    // Scoreboard: expected head words pushed with stimulus, popped when shown.
    typedef struct {
        logic [21:0] a;
        logic [63:0] d;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_exp(input logic [21:0] a);
        exp_t e;
        e.a = a;
        e.d = mdata(a);
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (!reset && bus.video_valid) begin
            check("stale_word", bus.video_data, mdata(bus.video_addr));
            if (exp_q.size() != 0 && exp_q[0].a == bus.video_addr) begin
                check("sb_data", bus.video_data, exp_q[0].d);
                void'(exp_q.pop_front());
            end
        end
    end

    function automatic int probe(input int sel);
        case (sel)
            0:       return int'(dut.count_q);
            1:       return int'(dut.inflight_q);
            2:       return int'(dut.discard_q);
            default: return int'(bus.video_valid);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_probe(input string tag, input int sel, input int val, input int budget);
        int n = 0;
        while (probe(sel) != val && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(probe(sel)), 64'(val));
    endtask

    task automatic jump(input logic [21:0] addr, input string tag, output bit a, output bit r);
        int d0;
        int i0;
        @(negedge clk);
        req_chk = 1'b0;
        bus.video_addr = addr;
        d0 = int'(dut.discard_q);
        i0 = int'(dut.inflight_q);
        @(posedge clk);
        a = bus.mem_req & bus.mem_ack;
        r = bus.mem_rvalid;
        #1;
        check({tag, "_discard"}, 64'(dut.discard_q), 64'(d0 + i0 + int'(a) - int'(r)));
        check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(addr));
        check({tag, "_count"}, 64'(dut.count_q), 64'd0);
        req_exp = addr;
        req_chk = 1'b1;
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit a;
        bit r;
        logic [21:0] u;

        reset          = 1'b1;
        bus.video_addr = 22'h0F4000;
        ack_en         = 1'b0;
        lat            = 4;
        req_chk        = 1'b0;
        req_exp        = '0;
        repeat (3) tick();

        // Reset state
        check("rst_count",    64'(dut.count_q),    64'd0);
        check("rst_inflight", 64'(dut.inflight_q), 64'd0);
        check("rst_discard",  64'(dut.discard_q),  64'd0);
        check("rst_head",     64'(dut.head_addr_q), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr),   64'd0);
        check("rst_mem_req",  64'(bus.mem_req),    64'd1);
        check("rst_valid",    64'(bus.video_valid), 64'd0);
        check("rst_data",     bus.video_data,      64'd0);

        // First fill at 0F4000
        @(negedge clk);
        reset = 1'b0;
        tick();
        req_exp = 22'h0F4000;
        req_chk = 1'b1;
        ack_en  = 1'b1;
        push_exp(22'h0F4000);
        wait_probe("fill_valid", 3, 1, 30);
        wait_probe("fill_full", 0, 16, 60);
        tick();
        check("fill_reqs",    64'(req_exp),     64'h0F4010);
        check("fill_mem_req", 64'(bus.mem_req), 64'd0);

        // Sequential scan of 40 words, one step per 32 cycles
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.video_addr = 22'h0F4000 + 22'(k);
            push_exp(bus.video_addr);
            tick();
            check("scan_valid", 64'(bus.video_valid), 64'd1);
            check("scan_count", 64'(dut.count_q >= 5'd14), 64'd1);
            repeat (31) tick();
        end

        // Flush with data in flight
        lat = 10;
        jump(22'h0F8000, "j1", a, r);
        wait_probe("j1_inflight6", 1, 6, 20);
        jump(22'h0FA000, "j2", a, r);
        push_exp(22'h0FA000);
        wait_probe("j2_valid", 3, 1, 60);
        wait_probe("j2_discard0", 2, 0, 60);
        wait_probe("j2_full", 0, 16, 80);

        // Flush coincident with ack and rvalid
        lat = 4;
        jump(22'h0FC000, "j3", a, r);
        repeat (7) tick();
        jump(22'h0FD000, "j4", a, r);
        check("j4_ack",    64'(a), 64'd1);
        check("j4_rvalid", 64'(r), 64'd1);
        push_exp(22'h0FD000);
        wait_probe("j4_valid", 3, 1, 40);
        wait_probe("j4_full", 0, 16, 60);

        // Backpressure then fill
        ack_en = 1'b0;
        jump(22'h100000, "j5", a, r);
        for (int n = 0; n < 100; n++) begin
            tick();
            check("bp_hold", {41'd0, bus.mem_req, bus.mem_addr}, {41'd0, 1'b1, 22'h100000});
        end
        ack_en = 1'b1;
        push_exp(22'h100000);
        wait_probe("bp_valid", 3, 1, 30);
        wait_probe("bp_full", 0, 16, 60);
        for (int n = 0; n < 5; n++) begin
            tick();
            check("full_no_req", {62'd0, bus.mem_req, dut.count_q == 5'd16}, {62'd0, 1'b0, 1'b1});
        end

        // Underrun across the 3FFFFF -> 0 wrap
        u = 22'h3FFFF8;
        jump(u, "j6", a, r);
        push_exp(u);
        wait_probe("ur_valid", 3, 1, 30);
        wait_probe("ur_full", 0, 16, 60);
        req_chk = 1'b0;
        lat     = 40;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            bus.video_addr = u + 22'(k);
            if (k <= 15) push_exp(bus.video_addr);
            tick();
            check("ur_step_valid", 64'(bus.video_valid), 64'(k <= 15));
`ifdef VDU_FETCH_UNDERRUN_EN
            check("ur_count", 64'(underrun_count), 64'((k > 16) ? k - 16 : 0));
`endif
        end
        check("ur_mem_addr", 64'(bus.mem_addr), 64'h000012);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-operation
        reset = 1'b1;
        repeat (2) tick();
        check("rst2_count",    64'(dut.count_q),     64'd0);
        check("rst2_inflight", 64'(dut.inflight_q),  64'd0);
        check("rst2_discard",  64'(dut.discard_q),   64'd0);
        check("rst2_mem_addr", 64'(bus.mem_addr),    64'd0);
        check("rst2_valid",    64'(bus.video_valid), 64'd0);
        check("rst2_mem_req",  64'(bus.mem_req),     64'd1);
`ifdef VDU_FETCH_UNDERRUN_EN
        check("rst2_underrun", 64'(underrun_count),  64'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
